alu_issue_decoder: RTL and testbench
====================================

// Module: alu_issue_decoder
// PURPOSE
//  Registered decode stage that drives the branch-side ALU: accepts one RV32I/Zbb
//  instruction with its operand values, produces ALU select code, muxed operands and shamt.
//  Resolves SLT/SLTU/SLTI/SLTIU compares locally into constant-0/1 select codes.
//  Valid/ready on both sides with a 2-entry skid buffer; sits between issue and execute.
// PARAMETERS
//  XLEN        32   operand/PC width (only 32 supported)
//  SEL_W       5    ALU select width
// PORTS
//  clk         in   1      clock, rising edge
//  rst         in   1      asynchronous, active-high reset
//  flush       in   1      synchronous pipeline kill
//  in_valid    in   1      upstream has an instruction
//  in_ready    out  1      stage can accept (registered)
//  in_instr    in   32     instruction word
//  in_pc       in   32     instruction PC
//  in_rs1      in   32     rs1 value (forwarded)
//  in_rs2      in   32     rs2 value (forwarded)
//  out_valid   out  1      decoded op available
//  out_ready   in   1      ALU side accepts
//  out_sel     out  5      ALU select
//  out_num1    out  32     ALU operand 1
//  out_num2    out  32     ALU operand 2
//  out_shamt   out  5      instr[24:20]
//  out_pc      out  32     PC pass-through
//  out_illegal out  1      unsupported encoding
// BEHAVIOUR
//  Select codes: 0 ADD,1 SUB,2 OR,3 XOR,4 AND,5 SLL,6 SRL,7 SRA,8 SLLI,9 SRLI,
//   11 ZERO,12 ONE,13 PASS1,14 CLZ,15 CTZ,16 CPOP.
//  Decode (opcode 0110011 OP): ADD/SUB/OR/XOR/AND/SLL/SRL/SRA -> codes 0..7, num1=rs1,num2=rs2.
//  SLT: sel=12 if $signed(rs1)<$signed(rs2) else 11; SLTU unsigned compare; same for SLTI/SLTIU vs imm.
//  OP-IMM 0010011: ADDI/XORI/ORI/ANDI -> 0/3/2/4, num2=sign-extended I-imm.
//  SLLI->8, SRLI->9 (funct7=0000000); SRAI (0100000) -> sel 7, num2={27'b0,shamt}.
//  Zbb funct3=001,funct7=0110000: rs2 field 0/1/2 -> CLZ 14/CTZ 15/CPOP 16; other -> illegal.
//  LUI: sel 13, num1={imm[31:12],12'b0}. AUIPC: sel 0, num1=pc, num2=U-imm.
//  Any other opcode/funct combo: out_illegal=1, sel=11, num1=num2=0; still handshaken normally.
//  Handshake: transfer when valid&&ready. Accept at edge N -> out_valid at N+1 (latency 1).
//  Output payload stable while out_valid&&!out_ready; out_valid never drops without transfer.
//  Skid: main reg + 1 skid entry; in_ready = !skid_full (register, no comb path from out_ready).
//  Accept while main held -> skid filled, in_ready=0 next cycle; on drain skid -> main, in_ready=1.
//  Simultaneous out transfer and in accept with skid empty: new op goes to main, no bubble.
//  Order strictly FIFO; no drop, no duplicate.
//  flush: both entries invalid next edge; in_valid in same cycle ignored; in_ready=1 after.
//  Reset: out_valid=0, in_ready=1 (after deassert), all payload outputs/skid cleared to 0.
//  Reset mid-transfer discards both entries; nothing emitted.
// TESTING
//  ADD x3,x1,x2 (0x002081B3), rs1=5,rs2=7 -> next cycle sel=0,num1=5,num2=7,valid=1.
//  SLTI imm=-1, rs1=0x80000000 -> sel=12; SLTIU imm=-1, rs1=5 -> sel=12; rs1=0xFFFFFFFF -> sel=11.
//  SRAI shamt=4 -> sel=7,num2=4; CPOP (0x60209093) -> sel=16; opcode 0x63 -> illegal=1,sel=11.
//  Stream 4 ops, out_ready=0 for 3 cycles -> in_ready drops after 2 accepts, outputs stable, order kept.
//  flush with both entries full and in_valid=1 -> out_valid=0, in_ready=1 next cycle, op lost.
//  Assert rst mid-stream async -> out_valid=0 immediately; after release first op has latency 1.

Source files
------------

// File: rtl/alu_issue_decoder.sv
// alu_issue_decoder: registered RV32I/Zbb decode into ALU select and operands, with a 2-entry skid buffer
module alu_issue_decoder #(
  parameter int XLEN  = 32,
  parameter int SEL_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_rs1,
  input  logic [XLEN-1:0]  in_rs2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SEL_W-1:0] out_sel,
  output logic [XLEN-1:0]  out_num1,
  output logic [XLEN-1:0]  out_num2,
  output logic [4:0]       out_shamt,
  output logic [XLEN-1:0]  out_pc,
  output logic             out_illegal
);
  localparam logic [SEL_W-1:0] S_ADD = 0, S_SUB = 1, S_OR = 2, S_XOR = 3, S_AND = 4, S_SLL = 5,
    S_SRL = 6, S_SRA = 7, S_SLLI = 8, S_SRLI = 9, S_ZERO = 11, S_ONE = 12, S_PASS1 = 13, S_CLZ = 14;
  typedef struct packed {
    logic [SEL_W-1:0] sel;
    logic [XLEN-1:0]  num1;
    logic [XLEN-1:0]  num2;
    logic [4:0]       shamt;
    logic [XLEN-1:0]  pc;
    logic             illegal;
  } ent_t;
  ent_t dec, main_q, main_d, skid_q, skid_d;
  logic main_v_q, main_v_d, skid_v_q, skid_v_d, in_ready_q, in_ready_d;
  logic bad, lt, ltu, out_fire, in_fire;
  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [4:0] rs2f;
  logic [XLEN-1:0] imm, uimm, cmp_b;
  logic unused_fields;
  assign unused_fields = ^{in_instr[19:15], in_instr[11:7]};
  assign opc   = in_instr[6:0];
  assign f3    = in_instr[14:12];
  assign f7    = in_instr[31:25];
  assign rs2f  = in_instr[24:20];
  assign imm   = {{20{in_instr[31]}}, in_instr[31:20]};
  assign uimm  = {in_instr[31:12], 12'b0};
  assign cmp_b = opc == 7'b0110011 ? in_rs2 : imm;
  assign lt    = $signed(in_rs1) < $signed(cmp_b);
  assign ltu   = in_rs1 < cmp_b;
  always_comb begin
    dec = '0;
    dec.num1 = in_rs1;
    dec.num2 = in_rs2;
    dec.shamt = rs2f;
    dec.pc = in_pc;
    bad = 1'b0;
    case (opc)
      7'b0110011:
        case ({f7, f3})
          {7'h00, 3'd0}: dec.sel = S_ADD;
          {7'h20, 3'd0}: dec.sel = S_SUB;
          {7'h00, 3'd6}: dec.sel = S_OR;
          {7'h00, 3'd4}: dec.sel = S_XOR;
          {7'h00, 3'd7}: dec.sel = S_AND;
          {7'h00, 3'd1}: dec.sel = S_SLL;
          {7'h00, 3'd5}: dec.sel = S_SRL;
          {7'h20, 3'd5}: dec.sel = S_SRA;
          {7'h00, 3'd2}: dec.sel = lt ? S_ONE : S_ZERO;
          {7'h00, 3'd3}: dec.sel = ltu ? S_ONE : S_ZERO;
          default:       bad = 1'b1;
        endcase
      7'b0010011: begin
        dec.num2 = imm;
        case (f3)
          3'd0: dec.sel = S_ADD;
          3'd2: dec.sel = lt ? S_ONE : S_ZERO;
          3'd3: dec.sel = ltu ? S_ONE : S_ZERO;
          3'd4: dec.sel = S_XOR;
          3'd6: dec.sel = S_OR;
          3'd7: dec.sel = S_AND;
          3'd1: begin
            dec.sel = f7 == 7'h00 ? S_SLLI : S_CLZ + SEL_W'(rs2f);
            bad = !(f7 == 7'h00 || (f7 == 7'h30 && rs2f < 5'd3));
          end
          default: begin
            dec.sel = f7 == 7'h00 ? S_SRLI : S_SRA;
            dec.num2 = f7 == 7'h00 ? imm : {{(XLEN-5){1'b0}}, rs2f};
            bad = !(f7 == 7'h00 || f7 == 7'h20);
          end
        endcase
      end
      7'b0110111: begin
        dec.sel = S_PASS1;
        dec.num1 = uimm;
        dec.num2 = '0;
      end
      7'b0010111: begin
        dec.sel = S_ADD;
        dec.num1 = in_pc;
        dec.num2 = uimm;
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      dec.sel = S_ZERO;
      dec.num1 = '0;
      dec.num2 = '0;
      dec.illegal = 1'b1;
    end
  end
  // skid only fills while main is held, so it is always empty when main is free
  always_comb begin
    out_fire = main_v_q & out_ready;
    in_fire = in_valid & in_ready_q & ~flush;
    main_d = main_q;
    main_v_d = main_v_q;
    skid_d = skid_q;
    skid_v_d = skid_v_q;
    if (!main_v_q || out_fire) begin
      main_v_d = skid_v_q | in_fire;
      main_d = skid_v_q ? skid_q : in_fire ? dec : main_q;
      skid_v_d = 1'b0;
    end else if (in_fire) begin
      skid_v_d = 1'b1;
      skid_d = dec;
    end
    if (flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end
    in_ready_d = !skid_v_d;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      main_q <= main_d;
      skid_q <= skid_d;
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      in_ready_q <= in_ready_d;
    end
  end
  assign in_ready    = in_ready_q;
  assign out_valid   = main_v_q;
  assign out_sel     = main_q.sel;
  assign out_num1    = main_q.num1;
  assign out_num2    = main_q.num2;
  assign out_shamt   = main_q.shamt;
  assign out_pc      = main_q.pc;
  assign out_illegal = main_q.illegal;
endmodule

// File: tb/tb_alu_issue_decoder.sv
// tb_alu_issue_decoder: scoreboard bench for the ALU issue decoder and its skid buffer
module tb_alu_issue_decoder;
  logic clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, out_illegal;
  logic [31:0] in_instr = '0, in_pc = '0, in_rs1 = '0, in_rs2 = '0;
  logic [31:0] out_num1, out_num2, out_pc;
  logic [4:0] out_sel, out_shamt;
  logic [127:0] q[$];
  logic [127:0] snap, e;
  int checks = 0, errors = 0;
  logic done = 1'b0;
  always #5 clk = ~clk;
  alu_issue_decoder dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .out_valid(out_valid), .out_ready(out_ready), .out_sel(out_sel), .out_num1(out_num1),
    .out_num2(out_num2), .out_shamt(out_shamt), .out_pc(out_pc), .out_illegal(out_illegal)
  );
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask
  function automatic logic [127:0] payload();
    return {21'b0, out_sel, out_num1, out_num2, out_shamt, out_pc, out_illegal};
  endfunction
  function automatic logic [127:0] model(input logic [31:0] i, pc, a, b);
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic [4:0] sh, s;
    logic [31:0] imm, u, x, y;
    logic bad;
    op = i[6:0]; f7 = i[31:25]; f3 = i[14:12]; sh = i[24:20];
    imm = {{20{i[31]}}, i[31:20]}; u = {i[31:12], 12'b0};
    s = 0; x = a; y = b; bad = 0;
    if (op == 7'h33) begin
      if (f7 == 0) begin
        if (f3 == 0) s = 0;
        else if (f3 == 1) s = 5;
        else if (f3 == 2) s = ($signed(a) < $signed(b)) ? 12 : 11;
        else if (f3 == 3) s = (a < b) ? 12 : 11;
        else if (f3 == 4) s = 3;
        else if (f3 == 5) s = 6;
        else if (f3 == 6) s = 2;
        else s = 4;
      end else if (f7 == 7'h20 && f3 == 0) s = 1;
      else if (f7 == 7'h20 && f3 == 5) s = 7;
      else bad = 1;
    end else if (op == 7'h13) begin
      y = imm;
      if (f3 == 0) s = 0;
      else if (f3 == 2) s = ($signed(a) < $signed(imm)) ? 12 : 11;
      else if (f3 == 3) s = (a < imm) ? 12 : 11;
      else if (f3 == 4) s = 3;
      else if (f3 == 6) s = 2;
      else if (f3 == 7) s = 4;
      else if (f3 == 1) begin
        if (f7 == 0) s = 8;
        else if (f7 == 7'h30 && sh <= 2) s = 14 + sh;
        else bad = 1;
      end else begin
        if (f7 == 0) s = 9;
        else if (f7 == 7'h20) begin s = 7; y = {27'b0, sh}; end
        else bad = 1;
      end
    end else if (op == 7'h37) begin s = 13; x = u; y = 0; end
    else if (op == 7'h17) begin s = 0; x = pc; y = u; end
    else bad = 1;
    if (bad) begin s = 11; x = 0; y = 0; end
    return {21'b0, s, x, y, sh, pc, bad};
  endfunction
  function automatic logic [31:0] rand_instr();
    logic [31:0] i;
    logic [6:0] f7s[4];
    i = $urandom;
    f7s[0] = 7'h00; f7s[1] = 7'h20; f7s[2] = 7'h30; f7s[3] = i[31:25];
    case ($urandom_range(0, 5))
      0: i[6:0] = 7'h33;
      1, 2: i[6:0] = 7'h13;
      3: i[6:0] = 7'h37;
      4: i[6:0] = 7'h17;
      default: ;
    endcase
    if (i[6:0] == 7'h33 || (i[6:0] == 7'h13 && (i[14:12] == 1 || i[14:12] == 5))) begin
      i[31:25] = f7s[$urandom_range(0, 3)];
      if ($urandom_range(0, 1) == 1) i[24:20] = 5'($urandom_range(0, 3));
    end
    return i;
  endfunction
  function automatic logic [31:0] rand_val();
    logic [31:0] v[5];
    v[0] = 0; v[1] = 32'h8000_0000; v[2] = 32'hFFFF_FFFF; v[3] = 1; v[4] = $urandom;
    return v[$urandom_range(0, 4)];
  endfunction
  always @(negedge clk) if (!rst) begin
    if (out_valid && out_ready) begin
      if (q.size() == 0) chk("spurious_out", 1, 0);
      else begin
        e = q.pop_front();
        chk("payload", payload(), e);
      end
    end
    if (flush) q.delete();
    else if (in_valid && in_ready) q.push_back(model(in_instr, in_pc, in_rs1, in_rs2));
  end
  task automatic send(input logic [31:0] i, pc, a, b);
    logic acc;
    int n;
    in_valid = 1; in_instr = i; in_pc = pc; in_rs1 = a; in_rs2 = b;
    n = 0;
    do begin
      acc = in_ready;
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 100);
    if (!acc) chk("accept_timeout", 0, 1);
    in_valid = 0;
  endtask
  task automatic one(input string tag, input logic [31:0] i, a, b, input logic [4:0] sel, input logic ill);
    send(i, 32'h100, a, b);
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_sel"}, out_sel, sel);
    chk({tag, "_illegal"}, out_illegal, ill);
    @(posedge clk); #1;
  endtask
  task automatic drain();
    int n;
    out_ready = 1;
    n = 0;
    while ((q.size() != 0 || out_valid) && n < 50) begin @(posedge clk); #1; n++; end
    chk("drain", q.size(), 0);
  endtask
  initial begin
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_payload", payload(), 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("rst_in_ready", in_ready, 1);
    send(32'h002081B3, 32'h40, 5, 7);
    chk("add_valid", out_valid, 1);
    chk("add_sel", out_sel, 0);
    chk("add_num1", out_num1, 5);
    chk("add_num2", out_num2, 7);
    @(posedge clk); #1;
    one("slti_neg", 32'hFFF0A193, 32'h8000_0000, 0, 12, 0);
    one("sltiu_lt", 32'hFFF0B193, 5, 0, 12, 0);
    one("sltiu_ge", 32'hFFF0B193, 32'hFFFF_FFFF, 0, 11, 0);
    one("srai", 32'h4040D193, 32'hF000_0000, 0, 7, 0);
    chk("srai_num2", out_num2, 4);
    one("cpop", 32'h60209093, 32'h00FF, 0, 16, 0);
    one("branch", 32'h00000063, 1, 2, 11, 1);
    drain();
    // back-pressure: two accepts fill main and skid
    out_ready = 0;
    send(32'h002081B3, 32'h200, 1, 2);
    send(32'h402081B3, 32'h204, 3, 4);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    snap = payload();
    repeat (3) begin
      @(posedge clk); #1;
      chk("bp_stable", payload(), snap);
    end
    out_ready = 1;
    send(32'h0020E1B3, 32'h208, 5, 6);
    send(32'h0020C1B3, 32'h20C, 7, 8);
    drain();
    // flush with both entries full and a new op offered
    out_ready = 0;
    send(32'h002081B3, 32'h300, 1, 1);
    send(32'h002081B3, 32'h304, 2, 2);
    in_valid = 1; in_instr = 32'h002081B3; in_pc = 32'h308; flush = 1;
    @(posedge clk); #1;
    flush = 0; in_valid = 0;
    chk("flush_out_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    out_ready = 1;
    repeat (3) @(posedge clk);
    #1 chk("flush_lost", out_valid, 0);
    // random stream under random back-pressure
    fork
      begin
        for (int k = 0; k < 150; k++) begin
          send(rand_instr(), $urandom, rand_val(), rand_val());
          if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = $urandom_range(0, 3) != 0;
        end
      end
    join
    drain();
    // asynchronous reset with both entries occupied
    out_ready = 0;
    send(32'h002081B3, 32'h400, 1, 1);
    send(32'h002081B3, 32'h404, 2, 2);
    #3 rst = 1;
    q.delete();
    #1 chk("arst_out_valid", out_valid, 0);
    @(posedge clk); #1 rst = 0;
    chk("arst_in_ready", in_ready, 1);
    out_ready = 1;
    send(32'h002081B3, 32'h500, 9, 10);
    chk("arst_lat_valid", out_valid, 1);
    chk("arst_lat_num1", out_num1, 9);
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
